enemy_spawner: RTL and testbench
================================

// Module: enemy_spawner
// PURPOSE
//  Upstream stimulus stage for game_design in the 20x15 shooter. Generates the enemy_spawn pulse
//  and the enemy_init_x/enemy_init_y spawn coordinates that game_design samples on that pulse.
//  Spawn timing comes from an interval counter that shortens as score rises. Positions come from
//  a 16-bit LFSR. No spawn is issued while all three enemy slots are occupied.
// PARAMETERS
//  GRID_W         20       playfield width; enemy_init_x is always in 0..GRID_W-1
//  Y_BITS         2        enemy_init_y = zero-extended LFSR[9:8] (spawn rows 0..2^Y_BITS-1)
//  INTERVAL_INIT  40       cycles between spawns at score 0; legal range 2..255
//  INTERVAL_MIN   10       floor for the spawn interval; 2 <= MIN <= INIT
//  INTERVAL_STEP  4        interval decrement per score milestone
//  SCORE_STEP     5        score points per milestone
//  LFSR_SEED      16'hACE1 LFSR reset value; must be non-zero
// PORTS
//  clk             in   1  system clock
//  rst_n           in   1  asynchronous active-low reset
//  enable          in   1  1 = spawning runs; 0 = freeze
//  enemy0_active   in   1  slot status from game_design
//  enemy1_active   in   1  slot status from game_design
//  enemy2_active   in   1  slot status from game_design
//  score           in   8  current score from game_design
//  enemy_spawn     out  1  single-cycle spawn request to game_design
//  enemy_init_x    out  5  spawn column; stable between pulses
//  enemy_init_y    out  4  spawn row; stable between pulses
//  spawn_interval  out  8  interval currently in force
//  spawn_count     out  8  spawns issued; wraps 255->0
// BEHAVIOUR
//  Reset (async, rst_n=0), all registers:
//   - state=IDLE; enemy_spawn=0; enemy_init_x=0; enemy_init_y=0; spawn_count=0.
//   - spawn_interval=INTERVAL_INIT; milestone threshold=SCORE_STEP; lfsr=LFSR_SEED; last_x=5'h1F.
//  LFSR:
//   - Galois, mask 16'hB400; steps once per clock while enable=1. Held while enable=0.
//  Candidate position:
//   - cx = lfsr[4:0]; if cx>=GRID_W then cx-=GRID_W.
//   - If cx==last_x, cx = (last_x==GRID_W-1) ? 0 : last_x+1. No two consecutive spawns share a column.
//  FSM states: IDLE, COUNT, WAIT_SLOT, FIRE.
//   - IDLE: enable=1 -> COUNT; counter loads spawn_interval.
//   - COUNT: counter decrements each cycle. At expiry:
//       if any enemyN_active==0 -> FIRE, else -> WAIT_SLOT.
//   - WAIT_SLOT: stays until any enemyN_active==0 is sampled, then -> FIRE.
//   - FIRE: enemy_spawn=1 for exactly this cycle.
//       On entry, enemy_init_x/enemy_init_y/last_x are registered together with the pulse.
//       spawn_count increments; counter reloads spawn_interval; -> COUNT.
//  Timing:
//   - With a free slot always available, the first pulse rises spawn_interval cycles after enable
//     is first sampled high. Successive rising edges are exactly spawn_interval cycles apart.
//   - WAIT_SLOT exit: the pulse is asserted in the cycle after the freed slot is sampled.
//  Difficulty:
//   - When score>=threshold: threshold+=SCORE_STEP and spawn_interval-=INTERVAL_STEP, saturating
//     at INTERVAL_MIN. At most one milestone per cycle; large score jumps catch up over cycles.
//   - score==0 while threshold>SCORE_STEP (game restart) restores INTERVAL_INIT/SCORE_STEP.
//   - Threshold is 9 bits; once past 255 no further steps occur.
//   - An interval change applies at the next counter reload only; the running count is unaffected.
//  enable=0 in any state:
//   - Next state is IDLE; enemy_spawn=0 from the next cycle. A FIRE in progress completes its one cycle.
//   - enemy_init_x/y hold; difficulty tracking continues.
//  Reset mid-operation: outputs go to reset values immediately, with no pulse completion.
// TESTING
//  T1 rst, enable=1, all slots free, score=0:
//     pulses at cycles 40/80/120; spawn_count 1/2/3; x in 0..19, y in 0..3.
//  T2 1000 spawns, slots free:
//     x always <20; never equal to previous x; every column 0..19 hit;
//     sequence matches C model seeded 0xACE1.
//  T3 all three active at expiry:
//     no pulse. Drop enemy1_active, sampled at cycle 57 -> single pulse at cycle 58.
//     Next pulse 40 cycles later.
//  T4 score 0->5->10:
//     spawn_interval 40->36->32. score=200 -> saturates at 10. score=0 -> back to 40.
//  T5 enable=0 at cycle 20:
//     no pulse, outputs hold. Re-enable -> pulse exactly 40 cycles later;
//     LFSR continues from the frozen value.
//  T6 rst_n low during a FIRE cycle:
//     enemy_spawn falls without waiting for a clock edge; all outputs at reset values;
//     restart reproduces T1.

Source files
------------

// File: rtl/enemy_spawner.sv
// Purpose: spawn pacing and spawn-column/row generation for the 20x15 shooter's enemy slots.
// Latency: enemy_spawn and the new coordinates are registered together on the edge that enters FIRE.
// Backpressure: when all three enemy slots are occupied at expiry, the spawn is held until a slot is seen free.
module enemy_spawner #(
    parameter int          GRID_W        = 20,
    parameter int          Y_BITS        = 2,
    parameter int          INTERVAL_INIT = 40,
    parameter int          INTERVAL_MIN  = 10,
    parameter int          INTERVAL_STEP = 4,
    parameter int          SCORE_STEP    = 5,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       enemy0_active,
    input  logic       enemy1_active,
    input  logic       enemy2_active,
    input  logic [7:0] score,
    output logic       enemy_spawn,
    output logic [4:0] enemy_init_x,
    output logic [3:0] enemy_init_y,
    output logic [7:0] spawn_interval,
    output logic [7:0] spawn_count
);

    localparam logic [15:0] LFSR_MASK  = 16'hB400;
    localparam logic [4:0]  GW         = 5'(GRID_W);
    localparam logic [4:0]  GW_LAST    = 5'(GRID_W - 1);
    localparam logic [7:0]  IV_INIT    = 8'(INTERVAL_INIT);
    localparam logic [7:0]  IV_MIN     = 8'(INTERVAL_MIN);
    localparam logic [7:0]  IV_STEP    = 8'(INTERVAL_STEP);
    localparam logic [8:0]  IV_FLOOR   = 9'(INTERVAL_MIN + INTERVAL_STEP);
    localparam logic [8:0]  THR_STEP   = 9'(SCORE_STEP);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNT     = 2'd1,
        WAIT_SLOT = 2'd2,
        FIRE      = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  counter;
    logic [8:0]  threshold;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [4:0]  last_x;
    logic [4:0]  cx_raw;
    logic [4:0]  cx_wrap;
    logic [4:0]  cx;
    logic [3:0]  cy;
    logic        any_free;
    logic        expired;
    logic        fire_entry;
    logic        load_start;

    assign any_free   = ~(enemy0_active & enemy1_active & enemy2_active);
    // Counter holds the remaining cycles; the value 1 means this edge is the spawn edge.
    assign expired    = (counter <= 8'd1);
    assign fire_entry = (next_state == FIRE);
    assign load_start = (state == IDLE) && (next_state == COUNT);

    // Galois LFSR next value and the candidate spawn position derived from the current value.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
        cx_raw    = lfsr[4:0];
        cx_wrap   = (cx_raw >= GW) ? (cx_raw - GW) : cx_raw;
        cx        = cx_wrap;
        // Never spawn twice in a row on the same column.
        if (cx_wrap == last_x) begin
            cx = (last_x == GW_LAST) ? 5'd0 : (last_x + 5'd1);
        end
        cy = 4'(lfsr[8 +: Y_BITS]);
    end

    // Next-state logic; dropping enable always parks the machine in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = COUNT;
                end
            end
            COUNT: begin
                if (expired) begin
                    next_state = any_free ? FIRE : WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                if (any_free) begin
                    next_state = FIRE;
                end
            end
            FIRE: begin
                next_state = COUNT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (!enable) begin
            next_state = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Interval counter: loaded on start and on each spawn; FIRE counts as the first cycle
    // of the next interval so pulse rising edges are exactly spawn_interval apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= IV_INIT;
        end else if (load_start || fire_entry) begin
            counter <= spawn_interval;
        end else if (((state == COUNT) || (state == FIRE)) && (counter != 8'd0)) begin
            counter <= counter - 8'd1;
        end
    end

    // Position generator advances only while spawning is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (enable) begin
            lfsr <= lfsr_next;
        end
    end

    // Spawn pulse, coordinates and spawn counter, all registered on FIRE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enemy_spawn  <= 1'b0;
            enemy_init_x <= 5'd0;
            enemy_init_y <= 4'd0;
            last_x       <= 5'h1F;
            spawn_count  <= 8'd0;
        end else begin
            enemy_spawn <= fire_entry;
            if (fire_entry) begin
                enemy_init_x <= cx;
                enemy_init_y <= cy;
                last_x       <= cx;
                spawn_count  <= spawn_count + 8'd1;
            end
        end
    end

    // Difficulty tracking runs regardless of enable; one milestone per cycle at most,
    // and a score of zero after progress means a new game.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spawn_interval <= IV_INIT;
            threshold      <= THR_STEP;
        end else if ((score == 8'd0) && (threshold > THR_STEP)) begin
            spawn_interval <= IV_INIT;
            threshold      <= THR_STEP;
        end else if ({1'b0, score} >= threshold) begin
            threshold <= threshold + THR_STEP;
            if ({1'b0, spawn_interval} >= IV_FLOOR) begin
                spawn_interval <= spawn_interval - IV_STEP;
            end else begin
                spawn_interval <= IV_MIN;
            end
        end
    end

endmodule

// File: tb/tb_enemy_spawner.sv
`timescale 1ns/1ps
module tb_enemy_spawner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       enemy0_active = 1'b0;
    logic       enemy1_active = 1'b0;
    logic       enemy2_active = 1'b0;
    logic [7:0] score = 8'd0;
    logic       enemy_spawn;
    logic [4:0] enemy_init_x;
    logic [3:0] enemy_init_y;
    logic [7:0] spawn_interval;
    logic [7:0] spawn_count;

    enemy_spawner dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .enemy0_active  (enemy0_active),
        .enemy1_active  (enemy1_active),
        .enemy2_active  (enemy2_active),
        .score          (score),
        .enemy_spawn    (enemy_spawn),
        .enemy_init_x   (enemy_init_x),
        .enemy_init_y   (enemy_init_y),
        .spawn_interval (spawn_interval),
        .spawn_count    (spawn_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;
    exp_t sb[$];

    // Reference position model: C-style Galois LFSR seeded 0xACE1.
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    logic [4:0]  m_last_x = 5'h1F;
    logic [3:0]  m_last_y = 4'd0;
    bit          cover_col[20];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            if (enable) m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    function automatic logic [4:0] model_x(input logic [15:0] l, input logic [4:0] last);
        logic [4:0] c;
        c = l[4:0];
        if (c >= 5'd20) c = c - 5'd20;
        if (c == last) c = (last == 5'd19) ? 5'd0 : last + 5'd1;
        return c;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input int n);
        exp_t e;
        e.cyc = c;
        e.cnt = n;
        sb.push_back(e);
    endtask

    // Monitor: every observed pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && enemy_spawn) begin
            logic [4:0] ex;
            logic [3:0] ey;
            exp_t e;
            ex = model_x(m_prev, m_last_x);
            ey = {2'b00, m_prev[9:8]};
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: pulse at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("spawn_count", int'(spawn_count), e.cnt);
                check("init_x_model", int'(enemy_init_x), int'(ex));
                check("init_y_model", int'(enemy_init_y), int'(ey));
                check("x_in_range", int'(enemy_init_x < 5'd20), 1);
                check("x_not_repeated", int'(enemy_init_x != m_last_x), 1);
            end
            if (enemy_init_x < 5'd20) cover_col[enemy_init_x] = 1'b1;
            m_last_x = ex;
            m_last_y = ey;
        end
    end

    task automatic wait_drain(input int budget, input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d pulses still outstanding, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        enemy0_active = 1'b0;
        enemy1_active = 1'b0;
        enemy2_active = 1'b0;
        score = 8'd0;
        m_last_x = 5'h1F;
        m_last_y = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_spawn", int'(enemy_spawn), 0);
        check("rst_x", int'(enemy_init_x), 0);
        check("rst_y", int'(enemy_init_y), 0);
        check("rst_count", int'(spawn_count), 0);
        check("rst_interval", int'(spawn_interval), 40);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Free-running spawns at score 0: pulses at 40/80/120 after enable is sampled.
    task automatic run_t1();
        int e0;
        enable = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 40, 1);
        push_exp(e0 + 80, 2);
        push_exp(e0 + 120, 3);
        wait_drain(200, "t1");
    endtask

    initial begin
        int e0;
        int r0;
        int hit;

        // T1
        do_reset();
        run_t1();

        // T3: all slots busy at expiry, slot 1 frees during cycle 57
        do_reset();
        enemy0_active = 1'b1;
        enemy1_active = 1'b1;
        enemy2_active = 1'b1;
        enable = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 58, 1);
        push_exp(e0 + 98, 2);
        while (cyc < e0 + 57) @(negedge clk);
        check("t3_no_pulse_yet", int'(spawn_count), 0);
        enemy1_active = 1'b0;
        wait_drain(200, "t3");

        // T4: difficulty ramp, saturation and restart
        do_reset();
        score = 8'd5;
        repeat (2) @(negedge clk);
        check("t4_interval_s5", int'(spawn_interval), 36);
        score = 8'd10;
        repeat (2) @(negedge clk);
        check("t4_interval_s10", int'(spawn_interval), 32);
        score = 8'd200;
        repeat (60) @(negedge clk);
        check("t4_interval_sat", int'(spawn_interval), 10);
        score = 8'd0;
        repeat (2) @(negedge clk);
        check("t4_interval_restart", int'(spawn_interval), 40);
        score = 8'd5;
        repeat (2) @(negedge clk);
        check("t4_threshold_restart", int'(spawn_interval), 36);

        // T5: freeze at cycle 20, re-enable, then freeze during a pulse cycle
        do_reset();
        enable = 1'b1;
        e0 = cyc + 1;
        while (cyc < e0 + 20) @(negedge clk);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        check("t5_frozen_count", int'(spawn_count), 0);
        check("t5_frozen_x", int'(enemy_init_x), 0);
        check("t5_frozen_y", int'(enemy_init_y), 0);
        enable = 1'b1;
        r0 = cyc + 1;
        push_exp(r0 + 40, 1);
        while (cyc < r0 + 40) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("t5_pulse_one_cycle", int'(enemy_spawn), 0);
        repeat (30) @(negedge clk);
        check("t5_hold_x", int'(enemy_init_x), int'(m_last_x));
        check("t5_hold_y", int'(enemy_init_y), int'(m_last_y));
        check("t5_hold_count", int'(spawn_count), 1);
        wait_drain(10, "t5");

        // T6: asynchronous reset during the FIRE cycle, then T1 again
        do_reset();
        enable = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 40, 1);
        while (cyc < e0 + 40) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_spawn", int'(enemy_spawn), 0);
        check("t6_async_x", int'(enemy_init_x), 0);
        check("t6_async_y", int'(enemy_init_y), 0);
        check("t6_async_count", int'(spawn_count), 0);
        check("t6_sb_empty", sb.size(), 0);
        sb.delete();
        do_reset();
        run_t1();

        // T2: 1000 spawns at the minimum interval
        do_reset();
        score = 8'd200;
        repeat (50) @(negedge clk);
        check("t2_interval", int'(spawn_interval), 10);
        foreach (cover_col[i]) cover_col[i] = 1'b0;
        enable = 1'b1;
        e0 = cyc + 1;
        for (int i = 0; i < 1000; i++) push_exp(e0 + 10 * (i + 1), (i + 1) % 256);
        wait_drain(10200, "t2");
        hit = 0;
        foreach (cover_col[i]) if (cover_col[i]) hit++;
        check("t2_columns_hit", hit, 20);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_empty_end", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
